// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op codes, FSM states and a magnitude helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

  localparam int unsigned MDU_MAXW = 64;

  function automatic logic [MDU_MAXW-1:0] abs_val(
    input logic [MDU_MAXW-1:0] x,
    input logic                neg
  );
    return neg ? (~x + MDU_MAXW'(1)) : x;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the pipeline and the MDU.
// Master issues start/op/a/b; slave returns busy/done/hi/lo.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_div_unit.sv
// Radix-2 iterative mul/div with HI/LO registers.
// Mul and div share one 2*WIDTH working register.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  mdu_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_mul_q, is_mul_d;
  logic               sgn_hi_q, sgn_hi_d;
  logic               sgn_lo_q, sgn_lo_d;
  logic               done_q, done_d;

  logic               is_iter, is_mthi, is_mtlo;
  logic               is_sgn, is_mul_op;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign is_mul_op = (bus.op == MDU_MULT)
                  || (bus.op == MDU_MULTU);
  assign is_iter   = is_mul_op
                  || (bus.op == MDU_DIV)
                  || (bus.op == MDU_DIVU);
  assign is_mthi   = (bus.op == MDU_MTHI);
  assign is_mtlo   = (bus.op == MDU_MTLO);
  assign is_sgn    = (bus.op == MDU_MULT)
                  || (bus.op == MDU_DIV);

  assign a_neg  = is_sgn & bus.a[WIDTH-1];
  assign b_neg  = is_sgn & bus.b[WIDTH-1];
  assign b_zero = (bus.b == '0);

  assign a_mag = WIDTH'(abs_val(MDU_MAXW'(bus.a), a_neg));
  assign b_mag = WIDTH'(abs_val(MDU_MAXW'(bus.b), b_neg));

  // shift-add: multiplier sits in the low half
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                  + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  // restoring divide: remainder high, quotient shifts in low
  assign div_sh   = work_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = {1'b0, div_sh} - {2'b00, opnd_q};
  assign div_ok   = ~div_diff[WIDTH+1];
  assign rem_new  = div_ok ? div_diff[WIDTH-1:0]
                           : div_sh[WIDTH-1:0];
  assign div_next = {rem_new, work_q[WIDTH-2:0], div_ok};

  always_comb begin
    fix_hi = work_q[2*WIDTH-1:WIDTH];
    fix_lo = work_q[WIDTH-1:0];
    if (is_mul_q) begin
      if (sgn_lo_q) {fix_hi, fix_lo} = -work_q;
    end else begin
      if (sgn_hi_q) fix_hi = -work_q[2*WIDTH-1:WIDTH];
      if (sgn_lo_q) fix_lo = -work_q[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_mul_d = is_mul_q;
    sgn_hi_d = sgn_hi_q;
    sgn_lo_d = sgn_lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      MDU_IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            is_iter: begin
              state_d  = MDU_CALC;
              cnt_d    = CNT_INIT;
              is_mul_d = is_mul_op;
              work_d   = is_mul_op
                       ? {{WIDTH{1'b0}}, b_mag}
                       : {{WIDTH{1'b0}}, a_mag};
              opnd_d   = is_mul_op ? a_mag : b_mag;
              sgn_hi_d = is_mul_op ? (a_neg ^ b_neg)
                                   : a_neg;
              // x/0 keeps an all-ones quotient
              sgn_lo_d = (a_neg ^ b_neg)
                       & (is_mul_op | ~b_zero);
            end
            is_mthi: hi_d = bus.a;
            is_mtlo: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      MDU_CALC: begin
        if (cnt_q == '0) begin
          state_d = MDU_FIX;
        end else begin
          work_d = is_mul_q ? mul_next : div_next;
          cnt_d  = cnt_q - CW'(1);
        end
      end
      MDU_FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        done_d  = 1'b1;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_mul_q <= 1'b0;
      sgn_hi_q <= 1'b0;
      sgn_lo_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_mul_q <= is_mul_d;
      sgn_hi_q <= sgn_hi_d;
      sgn_lo_q <= sgn_lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != MDU_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit.
// Drives a 32-bit and an 8-bit instance.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  mdu_if #(.WIDTH(32)) b32 ();
  mdu_if #(.WIDTH(8))  b8 ();

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32.slave)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } row_t;

  exp_t        sb[$];
  logic [15:0] sb8[$];

  function automatic exp_t model32(
    input mdu_op_t op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    exp_t e;
    logic signed [63:0] sa, sb_, p;
    logic signed [31:0] na, nb;
    e = '0;
    sa = 64'($signed(a));
    sb_ = 64'($signed(b));
    na = a;
    nb = b;
    case (op)
      MDU_MULT: begin
        p = sa * sb_;
        e = p;
      end
      MDU_MULTU: e = {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a;
        end else if (a == 32'h8000_0000 && b == '1) begin
          e.lo = a; e.hi = '0;
        end else begin
          e.lo = na / nb; e.hi = na % nb;
        end
      end
      MDU_DIVU: begin
        if (b == 0) begin
          e.lo = '1; e.hi = a;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic go32(
    input mdu_op_t op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clk);
    b32.start = 1'b1;
    b32.op = op;
    b32.a = a;
    b32.b = b;
    @(negedge clk);
    b32.start = 1'b0;
  endtask

  task automatic go8(
    input mdu_op_t op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    @(negedge clk);
    b8.start = 1'b1;
    b8.op = op;
    b8.a = a;
    b8.b = b;
    @(negedge clk);
    b8.start = 1'b0;
  endtask

  task automatic wait32(output int lat, output logic to);
    lat = 0;
    to = 1'b0;
    while (b32.done !== 1'b1) begin
      @(negedge clk);
      lat++;
      if (lat > 200) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait8(output int lat, output logic to);
    lat = 0;
    to = 1'b0;
    while (b8.done !== 1'b1) begin
      @(negedge clk);
      lat++;
      if (lat > 200) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({b32.busy, b32.done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00",
               {b32.busy, b32.done});
    end
    checks++;
    if ({b32.hi, b32.lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo: got %h want 0",
               {b32.hi, b32.lo});
    end
    checks++;
    if ({b8.busy, b8.done, b8.hi, b8.lo} !== 18'd0) begin
      errors++;
      $display("FAIL reset_w8: got %h want 0",
               {b8.busy, b8.done, b8.hi, b8.lo});
    end
  endtask

  task automatic test_mt;
    go32(MDU_MTHI, 32'hDEAD_BEEF, 32'h1);
    checks++;
    if (b32.hi !== 32'hDEAD_BEEF || b32.lo !== 32'd0) begin
      errors++;
      $display("FAIL mthi: got %h/%h want deadbeef/0",
               b32.hi, b32.lo);
    end
    checks++;
    if ({b32.busy, b32.done} !== 2'b00) begin
      errors++;
      $display("FAIL mthi_flags: got %b want 00",
               {b32.busy, b32.done});
    end
    go32(MDU_MTLO, 32'hCAFE_F00D, 32'h2);
    checks++;
    if (b32.hi !== 32'hDEAD_BEEF || b32.lo !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL mtlo: got %h/%h want deadbeef/cafef00d",
               b32.hi, b32.lo);
    end
    checks++;
    if ({b32.busy, b32.done} !== 2'b00) begin
      errors++;
      $display("FAIL mtlo_flags: got %b want 00",
               {b32.busy, b32.done});
    end
    go32(mdu_op_t'(3'd6), 32'h1111_1111, 32'h3);
    go32(mdu_op_t'(3'd7), 32'h2222_2222, 32'h4);
    checks++;
    if ({b32.busy, b32.done, b32.hi, b32.lo}
        !== {2'b00, 32'hDEAD_BEEF, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL nop67: got %b%b %h/%h",
               b32.busy, b32.done, b32.hi, b32.lo);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    logic to;
    exp_t e;
    sb.push_back({32'd0, 32'd15});
    go32(MDU_MULTU, 32'd3, 32'd5);
    b32.start = 1'b1;
    b32.op = MDU_DIV;
    b32.a = 32'h7777_7777;
    b32.b = 32'h0000_0009;
    repeat (3) @(negedge clk);
    b32.a = 32'h1234_0000;
    checks++;
    if (b32.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_high: got %b want 1", b32.busy);
    end
    checks++;
    if (b32.hi !== 32'hDEAD_BEEF || b32.lo !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL hold_hilo: got %h/%h want deadbeef/cafef00d",
               b32.hi, b32.lo);
    end
    repeat (2) @(negedge clk);
    b32.start = 1'b0;
    wait32(lat, to);
    e = sb.pop_front();
    checks++;
    if (to || {b32.hi, b32.lo} !== e) begin
      errors++;
      $display("FAIL busy_ignore: got %h want %h",
               {b32.hi, b32.lo}, e);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({b32.busy, b32.done} !== 2'b00) begin
      errors++;
      $display("FAIL busy_after: got %b want 00",
               {b32.busy, b32.done});
    end
  endtask

  task automatic test_table;
    row_t tbl[9];
    int lat;
    logic to;
    exp_t e;
    tbl[0] = '{MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h0000_0001};
    tbl[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002,
               32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{MDU_DIVU, 32'h0000_0064, 32'h0000_0007,
               32'h0000_0002, 32'h0000_000E};
    tbl[4] = '{MDU_DIVU, 32'h1234_5678, 32'h0000_0000,
               32'h1234_5678, 32'hFFFF_FFFF};
    tbl[5] = '{MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000};
    tbl[6] = '{MDU_DIV, 32'hFFFF_FF00, 32'h0000_0000,
               32'hFFFF_FF00, 32'hFFFF_FFFF};
    tbl[7] = '{MDU_MULT, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000};
    tbl[8] = '{MDU_MULT, 32'h0000_0007, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 32'hFFFF_FFEB};
    for (int i = 0; i < 9; i++) begin
      sb.push_back({tbl[i].hi, tbl[i].lo});
      go32(tbl[i].op, tbl[i].a, tbl[i].b);
      wait32(lat, to);
      e = sb.pop_front();
      checks++;
      if (to || lat != 34) begin
        errors++;
        $display("FAIL tbl%0d_lat: got %0d want 34", i, lat);
      end
      checks++;
      if ({b32.hi, b32.lo} !== e) begin
        errors++;
        $display("FAIL tbl%0d_res: got %h want %h",
                 i, {b32.hi, b32.lo}, e);
      end
    end
  endtask

  task automatic test_random;
    int lat;
    logic to;
    exp_t e;
    mdu_op_t op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = mdu_op_t'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 6 == 5) b = b >> $urandom_range(20, 31);
      sb.push_back(model32(op, a, b));
      go32(op, a, b);
      wait32(lat, to);
      e = sb.pop_front();
      checks++;
      if (to || {b32.hi, b32.lo} !== e) begin
        errors++;
        $display("FAIL rnd%0d op%0d %h %h: got %h want %h",
                 i, op, a, b, {b32.hi, b32.lo}, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic to;
    exp_t e;
    sb.push_back(model32(MDU_MULTU, 32'h0001_0000, 32'h0001_0000));
    go32(MDU_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait32(lat, to);
    sb.push_back(model32(MDU_DIVU, 32'd1000, 32'd33));
    b32.start = 1'b1;
    b32.op = MDU_DIVU;
    b32.a = 32'd1000;
    b32.b = 32'd33;
    e = sb.pop_front();
    checks++;
    if (to || {b32.hi, b32.lo} !== e) begin
      errors++;
      $display("FAIL b2b_first: got %h want %h",
               {b32.hi, b32.lo}, e);
    end
    @(negedge clk);
    b32.start = 1'b0;
    wait32(lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat != 34) begin
      errors++;
      $display("FAIL b2b_lat: got %0d want 34", lat);
    end
    checks++;
    if ({b32.hi, b32.lo} !== e) begin
      errors++;
      $display("FAIL b2b_second: got %h want %h",
               {b32.hi, b32.lo}, e);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    go32(MDU_MULT, 32'd5, 32'd6);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({b32.busy, b32.done, b32.hi, b32.lo} !== 66'd0) begin
      errors++;
      $display("FAIL rst_mid: got %b%b %h/%h want 0",
               b32.busy, b32.done, b32.hi, b32.lo);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b32.done === 1'b1 || b32.busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d want 0", pulses);
    end
  endtask

  task automatic test_w8;
    int lat;
    logic to;
    logic [15:0] e;
    sb8.push_back(16'h4000);
    go8(MDU_MULT, 8'h80, 8'h80);
    wait8(lat, to);
    e = sb8.pop_front();
    checks++;
    if (to || lat != 10) begin
      errors++;
      $display("FAIL w8_lat: got %0d want 10", lat);
    end
    checks++;
    if ({b8.hi, b8.lo} !== e) begin
      errors++;
      $display("FAIL w8_mult: got %h want %h",
               {b8.hi, b8.lo}, e);
    end
    sb8.push_back(16'h0080);
    go8(MDU_DIV, 8'h80, 8'hFF);
    wait8(lat, to);
    e = sb8.pop_front();
    checks++;
    if (to || {b8.hi, b8.lo} !== e) begin
      errors++;
      $display("FAIL w8_div_ovf: got %h want %h",
               {b8.hi, b8.lo}, e);
    end
    sb8.push_back(16'hFE01);
    go8(MDU_MULTU, 8'hFF, 8'hFF);
    wait8(lat, to);
    e = sb8.pop_front();
    checks++;
    if (to || {b8.hi, b8.lo} !== e) begin
      errors++;
      $display("FAIL w8_multu: got %h want %h",
               {b8.hi, b8.lo}, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    b32.start = 1'b0;
    b32.op = MDU_MULT;
    b32.a = '0;
    b32.b = '0;
    b8.start = 1'b0;
    b8.op = MDU_MULT;
    b8.a = '0;
    b8.b = '0;
    test_reset();
    test_mt();
    test_busy_ignore();
    test_table();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_w8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative, parametrised multiply/divide unit with architectural HI/LO result registers for the CPU datapath.
- Performs signed and unsigned multiply and divide, one radix-2 step per clock.
- Uses a start/busy/done handshake so the pipeline stalls on HI/LO reads while busy.
- Supports direct HI/LO writes (MTHI/MTLO).

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits; WIDTH is even and at least 4.

Ports:
clk  in  1  system clock, all state updates on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  3  operation code, type mdu_op_t
a  in  WIDTH  operand A (multiplicand/dividend/MT source)
b  in  WIDTH  operand B (multiplier/divisor)
busy  out  1  high while an iterative operation is in flight
done  out  1  one-cycle pulse when hi/lo take a new mul/div result
hi  out  WIDTH  HI register (product upper half / remainder)
lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts the operation and discards the partial result.
- Op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5. Codes 6 and 7 are treated as no-ops.
- States:
  - IDLE -> CALC when start=1 and op is MULT, MULTU, DIV or DIVU.
  - CALC -> FIX after WIDTH iterations.
  - FIX -> IDLE unconditionally.
- IDLE acceptance (edge N):
  - Latch magnitudes of a and b. Signed ops take two's-complement abs; unsigned ops pass through.
  - Latch result sign: product sign = a.msb ^ b.msb; quotient sign = a.msb ^ b.msb; remainder sign = a.msb. Signs are forced to 0 for unsigned ops.
  - Load counter=WIDTH.
- CALC:
  - One shift-add (mul) or restoring shift-subtract (div) step per cycle; counter decrements.
  - busy=1 from edge N+1 through the edge that leaves FIX.
- FIX (entered at edge N+WIDTH+1):
  - Apply signs. For signed mul, negate the 2*WIDTH product.
  - Write {hi,lo} at edge N+WIDTH+2. done=1 and busy=0 in the cycle following that edge.
  - Total latency: WIDTH+2 cycles from start edge to result visible.
- Multiply: {hi,lo} = full 2*WIDTH product. Signed result equals sign-extended a times sign-extended b, truncated to 2*WIDTH bits.
- Divide: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
- Divide by zero: computed without trap, deterministic. lo = all ones, hi = a (both signed and unsigned).
- Signed overflow, a = most-negative and b = -1: lo = most-negative value, hi = 0. This must fall out of the magnitude algorithm; no extra latency.
- MTHI/MTLO with start=1 in IDLE: hi (resp. lo) <= a at the next edge. No busy, no done, state stays IDLE.
- start while busy: ignored, and op/a/b changes do not affect the result. start in the done cycle is accepted (state is IDLE).
- hi/lo hold their previous values throughout CALC and FIX until the result write edge.
- done is never asserted together with start acceptance of a new iterative op on the same edge unless issued by the driver, in which case the new op proceeds normally.

Decomposition:
- Package mdu_pkg:
  - typedef enum logic [2:0] mdu_op_t (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO).
  - typedef enum of FSM states (MDU_IDLE, MDU_CALC, MDU_FIX).
  - Helper function abs_val.
- Single module; the shift-add and shift-subtract datapaths share the 2*WIDTH working register, so no sub-module.

Test Plan:
- MULT a=FFFFFFFF b=FFFFFFFF (WIDTH=32) -> hi=00000000, lo=00000001, done exactly 34 cycles after start edge. MULTU same operands -> hi=FFFFFFFE, lo=00000001.
- DIV a=FFFFFFF9 (-7) b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). DIVU a=00000064 b=00000007 -> lo=0000000E, hi=00000002.
- DIVU a=12345678 b=0 -> lo=FFFFFFFF, hi=12345678. DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=00000000.
- MTHI a=DEADBEEF, then MTLO a=CAFEF00D -> hi=DEADBEEF, lo=CAFEF00D one edge after each, busy and done stay 0. Then issue a second start with changed a/b during busy -> result matches the first operands only.
- MULT in flight, rst=1 at cycle 10 for one edge -> busy=0, done=0, hi=lo=0 next cycle, no later done pulse. Re-run with WIDTH=8: MULT a=80 b=80 -> hi=40, lo=00, latency 10 cycles.
